d_cache_sb: RTL and testbench

D_CACHE_SB -- requirements
Module: d_cache_sb

---
 rtl/d_cache_pkg.sv | 14 +
 rtl/be_dual_port_ram.sv | 30 +++
 rtl/d_cache_sb.sv | 108 ++++++++++
 tb/tb_d_cache_sb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared encodings and helpers for the store-buffered data cache
package d_cache_pkg;
    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    typedef enum logic [1:0] {IDLE, READ, RESP} ld_state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < n; i++) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/be_dual_port_ram.sv
// be_dual_port_ram: byte-enabled RAM, port A read/write, port B read-only, synchronous reads
module be_dual_port_ram
    import d_cache_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 32,
    localparam int AW = log2(DEPTH),
    localparam int BW = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_a,
    input  logic [BW-1:0]     be_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     addr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    // only the debug output register is reset; array contents persist
    always_ff @(posedge clock) begin
        if (we_a)
            for (int i = 0; i < BW; i++)
                if (be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
        rdata_a <= mem[addr_a];
        rdata_b <= reset ? '0 : mem[addr_b];
    end
endmodule

// File: rtl/d_cache_sb.sv
// d_cache_sb: data cache RAM fronted by a retire store buffer with load forwarding
module d_cache_sb
    import d_cache_pkg::*;
#(
    parameter int DEPTH    = 128,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int SB_DEPTH = 4,
    localparam int IW = log2(DEPTH),
    localparam int SW = log2(SB_DEPTH),
    localparam int BW = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [BW-1:0]     req_be,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              drain_stall,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic [TAG_W-1:0]  ld_tag,
    input  logic              ld_grant,
    output logic              st_ack,
    output logic [SW:0]       sb_count,
    input  logic [31:0]       ex_addr,
    output logic [DATA_W-1:0] ex_data_out
);
    logic [IW-1:0]     sb_idx  [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [BW-1:0]     sb_be   [SB_DEPTH];
    logic [SW-1:0]     head, tail;
    logic [IW-1:0]     req_idx, ld_idx;
    logic [DATA_W-1:0] ram_q, merged;
    logic              sb_full, ld_acc, st_acc, drain;
    ld_state_t         state, next_state;

    assign req_idx   = req_addr[IW+1:2];
    assign sb_full   = sb_count == (SW+1)'(SB_DEPTH);
    assign req_ready = !sb_full && (req_op == LS_STORE || state == IDLE);
    assign ld_acc    = req_valid && req_ready && req_op == LS_LOAD;
    assign st_acc    = req_valid && req_ready && req_op == LS_STORE;
    assign drain     = !reset && sb_count != '0 && !drain_stall && !ld_acc;
    assign ld_valid  = state == RESP;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = ld_acc ? READ : IDLE;
            READ:    next_state = RESP;
            RESP:    next_state = ld_grant ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    // walk oldest to youngest so the youngest matching byte wins
    always_comb begin
        merged = ram_q;
        for (int k = 0; k < SB_DEPTH; k++)
            if ((SW+1)'(k) < sb_count && sb_idx[head + SW'(k)] == ld_idx)
                for (int b = 0; b < BW; b++)
                    if (sb_be[head + SW'(k)][b]) merged[8*b +: 8] = sb_data[head + SW'(k)][8*b +: 8];
    end

    always_ff @(posedge clock) begin
        if (st_acc && !reset) begin
            sb_idx[tail]  <= req_idx;
            sb_data[tail] <= req_data;
            sb_be[tail]   <= req_be;
        end
        if (ld_acc) ld_idx <= req_idx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
            st_ack   <= 1'b0;
            ld_data  <= '0;
            ld_tag   <= '0;
        end else begin
            state    <= next_state;
            st_ack   <= st_acc;
            tail     <= tail + SW'(st_acc);
            head     <= head + SW'(drain);
            sb_count <= sb_count + (SW+1)'(st_acc) - (SW+1)'(drain);
            if (ld_acc) ld_tag <= req_tag;
            if (state == READ) ld_data <= merged;
        end
    end

    be_dual_port_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we_a    (drain),
        .be_a    (sb_be[head]),
        .addr_a  (drain ? sb_idx[head] : req_idx),
        .wdata_a (sb_data[head]),
        .rdata_a (ram_q),
        .addr_b  (ex_addr[IW+1:2]),
        .rdata_b (ex_data_out)
    );
endmodule

// File: tb/tb_d_cache_sb.sv
// tb_d_cache_sb: directed and random checks of d_cache_sb against a store-queue memory model
module tb_d_cache_sb;
    logic        clock = 0, reset = 0, req_valid = 0, req_op = 0, drain_stall = 0, ld_grant = 0;
    logic [31:0] req_addr = 0, req_data = 0, ex_addr = 0;
    logic [3:0]  req_be = 0;
    logic [4:0]  req_tag = 0;
    logic        req_ready, ld_valid, st_ack;
    logic [31:0] ld_data, ex_data_out;
    logic [4:0]  ld_tag;
    logic [2:0]  sb_count;

    d_cache_sb dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .req_tag(req_tag), .drain_stall(drain_stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_tag(ld_tag), .ld_grant(ld_grant), .st_ack(st_ack), .sb_count(sb_count),
        .ex_addr(ex_addr), .ex_data_out(ex_data_out)
    );

    always #5 clock = ~clock;

    typedef struct {int idx; logic [31:0] d; logic [3:0] be;} st_t;
    st_t         q[$];
    logic [31:0] rmem [128];
    bit          rinit [128];
    int          phase = 0, nvec = 0, nerr = 0;
    logic [31:0] pval, exp_ld, exp_ex;
    logic [4:0]  ptag, exp_tag;
    bit          exp_ack, ex_known;
    logic [31:0] ex_cur = 0;

    function automatic logic [31:0] apply(logic [31:0] o, logic [31:0] d, logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // architectural view of a word: RAM with every pending store applied in order
    function automatic logic [31:0] logical(int w);
        logic [31:0] v;
        v = rmem[w];
        foreach (q[i]) if (q[i].idx == w) v = apply(v, q[i].d, q[i].be);
        return v;
    endfunction

    task automatic chk(string t, logic [31:0] o, logic [31:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic step(bit rst, bit v, bit op, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                        logic [4:0] tg, bit stall, bit grant);
        bit rdy, la, sa, drn;
        int ew, w;
        reset = rst; req_valid = v; req_op = op; req_addr = a; req_data = d; req_be = be;
        req_tag = tg; drain_stall = stall; ld_grant = grant; ex_addr = ex_cur;
        #1;
        rdy = q.size() < 4 && (op || phase == 0);
        chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
        la = !rst && v && rdy && !op;
        sa = !rst && v && rdy && op;
        w = int'(a[8:2]);
        ew = int'(ex_cur[8:2]);
        @(posedge clock); #1;
        if (rst) begin
            q.delete(); phase = 0; exp_ack = 0; exp_ex = 0; ex_known = 1; exp_ld = 0; exp_tag = 0;
        end else begin
            ex_known = rinit[ew];
            exp_ex = rmem[ew];
            drn = q.size() > 0 && !stall && !la;
            if (la) begin pval = logical(w); ptag = tg; end
            if (drn) begin
                rmem[q[0].idx] = apply(rmem[q[0].idx], q[0].d, q[0].be);
                if (q[0].be == 4'hF) rinit[q[0].idx] = 1;
                void'(q.pop_front());
            end
            if (sa) q.push_back('{w, d, be});
            exp_ack = sa;
            if (phase == 2) phase = grant ? 0 : 2;
            else if (phase == 1) begin phase = 2; exp_ld = pval; exp_tag = ptag; end
            else if (la) phase = 1;
        end
        chk("sb_count", {29'd0, sb_count}, q.size());
        chk("st_ack", {31'd0, st_ack}, {31'd0, exp_ack});
        chk("ld_valid", {31'd0, ld_valid}, {31'd0, phase == 2});
        if (phase == 2 || rst) begin
            chk("ld_data", ld_data, exp_ld);
            chk("ld_tag", {27'd0, ld_tag}, {27'd0, exp_tag});
        end
        if (ex_known) chk("ex_data_out", ex_data_out, exp_ex);
    endtask

    task automatic idle(bit stall, bit grant);
        step(0, 0, 0, 0, 0, 0, 0, stall, grant);
    endtask
    task automatic st(logic [31:0] a, logic [31:0] d, logic [3:0] be, bit stall);
        step(0, 1, 1, a, d, be, 0, stall, 1);
    endtask
    task automatic ld(logic [31:0] a, logic [4:0] tg, bit stall, bit grant);
        step(0, 1, 0, a, 0, 0, tg, stall, grant);
    endtask
    task automatic flush();
        for (int i = 0; i < 20 && (q.size() > 0 || phase != 0); i++) idle(0, 1);
        chk("flushed", q.size() + phase, 0);
    endtask

    initial begin
        foreach (rinit[i]) rinit[i] = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 16; w++) st(w << 2, $urandom, 4'hF, 0);
        flush();

        ex_cur = 32'h10;
        st(32'h10, 32'hDEADBEEF, 4'hF, 0);
        idle(0, 1);
        ld(32'h10, 5'd7, 0, 1);
        idle(0, 1);
        idle(0, 0);
        chk("r21_ld_data", ld_data, 32'hDEADBEEF);
        chk("r21_ld_tag", {27'd0, ld_tag}, 32'd7);
        chk("r21_ex", ex_data_out, 32'hDEADBEEF);
        idle(0, 1);

        st(32'h20, 32'hAABBCCDD, 4'hF, 0);
        flush();
        st(32'h20, 32'h11223344, 4'h3, 1);
        ld(32'h20, 5'd3, 1, 0);
        idle(1, 0);
        idle(1, 0);
        chk("r22_merge", ld_data, 32'hAABB3344);
        idle(1, 1);
        flush();

        for (int i = 0; i < 4; i++) st(32'h40 + (i << 2), $urandom, 4'hF, 1);
        chk("r23_full", {29'd0, sb_count}, 32'd4);
        st(32'h50, 32'h1, 4'hF, 1);
        ld(32'h50, 5'd1, 1, 1);
        for (int i = 0; i < 4; i++) idle(0, 1);

        ld(32'h14, 5'd9, 0, 0);
        idle(0, 0);
        for (int i = 0; i < 3; i++) begin
            st(32'h18, $urandom, 4'hC, 0);
            ld(32'h1C, 5'd2, 0, 0);
        end
        idle(0, 1);
        ld(32'h18, 5'd4, 0, 1);
        flush();

        ex_cur = 32'h30;
        st(32'h30, 32'h12345678, 4'hF, 1);
        st(32'h30, 32'h9ABCDEF0, 4'h5, 1);
        ld(32'h30, 5'd5, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0, 1);
        ld(32'h30, 5'd6, 0, 1);
        flush();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FE00) | (($urandom % 16) << 2) | ($urandom & 3);
            ex_cur = ($urandom % 16) << 2;
            if ($urandom % 50 == 0) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
            else step(0, $urandom % 4 != 0, $urandom % 2, a, $urandom, 4'($urandom),
                      5'($urandom), $urandom % 3 == 0, $urandom % 2);
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
